// File: rtl/combo_entry.sv
// Combination entry front end: collects six 5-bit digits, strobes LOAD to the
// checker, samples res and drives unlocked/lockout. Optional ENTRY_TIMEOUT_EN adds an inter-digit timeout.
module combo_entry #(
  parameter int unsigned RES_WAIT    = 2,
  parameter int unsigned MAX_FAIL    = 3,
  parameter int unsigned LOCK_CYC    = 5000,
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       key_valid,
  input  logic [4:0] key_code,
  input  logic       clear,
  input  logic       res,
  output logic [4:0] check1,
  output logic [4:0] check2,
  output logic [4:0] check3,
  output logic [4:0] check4,
  output logic [4:0] check5,
  output logic [4:0] check6,
  output logic       LOAD,
  output logic [2:0] count,
  output logic       busy,
  output logic       unlocked,
  output logic       lockout,
  output logic       timeout
);

  // state   | meaning
  // COLLECT | accepting digits into check1..6
  // LOAD_S  | one-cycle LOAD strobe to the checker
  // WAIT_S  | waiting RES_WAIT cycles, res sampled on the last one
  // OPEN    | unlocked until clear
  // LOCKED  | lockout for LOCK_CYC cycles, inputs ignored
  typedef enum logic [2:0] {COLLECT, LOAD_S, WAIT_S, OPEN, LOCKED} state_t;

  // One down-counter serves the res wait, the lockout and the idle timeout.
  localparam int unsigned TMAX0 = (LOCK_CYC > RES_WAIT) ? LOCK_CYC : RES_WAIT;
  localparam int unsigned TMAX  = (TIMEOUT_CYC > TMAX0) ? TIMEOUT_CYC : TMAX0;
  localparam int          TW    = $clog2(TMAX + 1);
  localparam logic [TW-1:0] WAIT_LD = TW'(RES_WAIT - 1);
  localparam logic [TW-1:0] LOCK_LD = TW'(LOCK_CYC - 1);
  localparam logic [2:0]    MAX_F3  = 3'(MAX_FAIL);

  state_t          state_q, state_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic [5:0][4:0] chk_q, chk_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [2:0]      fail_q, fail_d;
  logic [2:0]      fail_inc;

  assign fail_inc = fail_q + 3'd1;

`ifdef ENTRY_TIMEOUT_EN
  localparam logic [TW-1:0] IDLE_LD = TW'(TIMEOUT_CYC - 1);
  logic tout_q, tout_d;
`endif

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    chk_d   = chk_q;
    cnt_d   = cnt_q;
    fail_d  = fail_q;
`ifdef ENTRY_TIMEOUT_EN
    tout_d  = 1'b0;
`endif
    case (state_q)
      COLLECT: begin
        if (clear) begin
          chk_d = '0;
          cnt_d = '0;
        end else if (key_valid) begin
          chk_d[cnt_q] = key_code;
          cnt_d        = cnt_q + 3'd1;
          if (cnt_q == 3'd5) state_d = LOAD_S;
`ifdef ENTRY_TIMEOUT_EN
          tmr_d = IDLE_LD;
`endif
        end
`ifdef ENTRY_TIMEOUT_EN
        else if (cnt_q != 3'd0) begin
          if (tmr_q == '0) begin
            chk_d  = '0;
            cnt_d  = '0;
            tout_d = 1'b1;
          end else begin
            tmr_d = tmr_q - 1'b1;
          end
        end
`endif
      end
      LOAD_S: begin
        state_d = WAIT_S;
        tmr_d   = WAIT_LD;
      end
      WAIT_S: begin
        if (tmr_q == '0) begin
          chk_d = '0;
          cnt_d = '0;
          if (res) begin
            state_d = OPEN;
            fail_d  = '0;
          end else begin
            fail_d = (fail_q >= MAX_F3) ? fail_q : fail_inc;
            if (fail_inc >= MAX_F3) begin
              state_d = LOCKED;
              tmr_d   = LOCK_LD;
            end else begin
              state_d = COLLECT;
            end
          end
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      OPEN: begin
        if (clear) state_d = COLLECT;
      end
      LOCKED: begin
        if (tmr_q == '0) begin
          state_d = COLLECT;
          fail_d  = '0;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= COLLECT;
      tmr_q   <= '0;
      chk_q   <= '0;
      cnt_q   <= '0;
      fail_q  <= '0;
`ifdef ENTRY_TIMEOUT_EN
      tout_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      chk_q   <= chk_d;
      cnt_q   <= cnt_d;
      fail_q  <= fail_d;
`ifdef ENTRY_TIMEOUT_EN
      tout_q  <= tout_d;
`endif
    end
  end

  assign check1   = chk_q[0];
  assign check2   = chk_q[1];
  assign check3   = chk_q[2];
  assign check4   = chk_q[3];
  assign check5   = chk_q[4];
  assign check6   = chk_q[5];
  assign count    = cnt_q;
  assign LOAD     = (state_q == LOAD_S);
  assign busy     = (state_q == LOAD_S) || (state_q == WAIT_S);
  assign unlocked = (state_q == OPEN);
  assign lockout  = (state_q == LOCKED);
`ifdef ENTRY_TIMEOUT_EN
  assign timeout  = tout_q;
`else
  assign timeout  = 1'b0;
`endif

endmodule
